// File: rtl/rotary_encoder_array_pkg.sv
// Shared definitions for the multi-channel rotary encoder block: button FSM states and
// quadrature transition codes.
package rotary_encoder_array_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPressed = 2'd1,
    StHeld    = 2'd2
  } btn_state_e;

  // Transition codes are {previous AB, current AB} of the filtered phase pair.
  localparam logic [3:0] QuadLeft  = 4'b10_11;
  localparam logic [3:0] QuadRight = 4'b01_11;

  function automatic logic quad_illegal(input logic [1:0] prev, input logic [1:0] cur);
    return (prev ^ cur) == 2'b11;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// W-bit 2-FF synchroniser plus per-bit debounce: a bit's filtered level flips only after
// the synchronised level has disagreed with it for N consecutive cycles.
module debounce_filter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic          filt_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync_q[i] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(N - 1)) begin
        filt_q <= ~filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign dout[i] = filt_q;
  end

endmodule

// File: rtl/rotary_encoder_array.sv
// CHANNELS quadrature knobs with push buttons: debounce, detent decode, position counters
// and button down/click/hold events, all synchronous to clk.
module rotary_encoder_array
  import rotary_encoder_array_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned QUAD_DEBOUNCE = 32,
  parameter int unsigned BTN_DEBOUNCE  = 512,
  parameter int unsigned LONG_PRESS    = 25000000,
  parameter int unsigned POS_WIDTH     = 8,
  parameter bit          WRAP          = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           rotA,
  input  logic [CHANNELS-1:0]           rotB,
  input  logic [CHANNELS-1:0]           rotCenter,
  input  logic [CHANNELS-1:0]           posClr,
  output logic [CHANNELS-1:0]           left,
  output logic [CHANNELS-1:0]           right,
  output logic [CHANNELS-1:0]           down,
  output logic [CHANNELS-1:0]           click,
  output logic [CHANNELS-1:0]           hold,
  output logic [CHANNELS-1:0]           quadErr,
  output logic [CHANNELS*POS_WIDTH-1:0] pos
);

  localparam int unsigned HW = $clog2(LONG_PRESS);

  logic [CHANNELS-1:0] filt_a;
  logic [CHANNELS-1:0] filt_b;
  logic [CHANNELS-1:0] filt_c;

  debounce_filter #(
    .N(QUAD_DEBOUNCE),
    .W(CHANNELS)
  ) u_filt_a (
    .clk (clk),
    .rst (rst),
    .din (rotA),
    .dout(filt_a)
  );

  debounce_filter #(
    .N(QUAD_DEBOUNCE),
    .W(CHANNELS)
  ) u_filt_b (
    .clk (clk),
    .rst (rst),
    .din (rotB),
    .dout(filt_b)
  );

  debounce_filter #(
    .N(BTN_DEBOUNCE),
    .W(CHANNELS)
  ) u_filt_c (
    .clk (clk),
    .rst (rst),
    .din (rotCenter),
    .dout(filt_c)
  );

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [1:0]           pair_q;
    logic [1:0]           prev_q;
    logic [3:0]           trans;
    logic                 step_l;
    logic                 step_r;
    logic                 illegal;
    logic [POS_WIDTH-1:0] pos_q;
    logic [POS_WIDTH-1:0] pos_dec;
    logic [POS_WIDTH-1:0] pos_inc;
    logic                 left_q;
    logic                 right_q;
    logic                 err_q;
    btn_state_e           st_q;
    logic [HW-1:0]        hcnt_q;
    logic                 down_q;
    logic                 click_q;
    logic                 hold_q;

    assign trans   = {prev_q, pair_q};
    assign step_l  = (trans == QuadLeft);
    assign step_r  = (trans == QuadRight);
    assign illegal = quad_illegal(prev_q, pair_q);

    // Saturating mode holds at the rails; wrap mode relies on natural overflow.
    always_comb begin
      pos_dec = pos_q - 1'b1;
      pos_inc = pos_q + 1'b1;
      if (!WRAP && (pos_q == '0)) pos_dec = pos_q;
      if (!WRAP && (&pos_q))      pos_inc = pos_q;
    end

    // pair_q/prev_q re-register the filtered levels so decode sees a clean one-cycle history.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pair_q  <= 2'b00;
        prev_q  <= 2'b00;
        left_q  <= 1'b0;
        right_q <= 1'b0;
        err_q   <= 1'b0;
        pos_q   <= '0;
      end else begin
        pair_q  <= {filt_a[c], filt_b[c]};
        prev_q  <= pair_q;
        left_q  <= step_l;
        right_q <= step_r;
        if (posClr[c]) begin
          pos_q <= '0;
          err_q <= 1'b0;
        end else begin
          if (illegal) err_q <= 1'b1;
          if (step_l) begin
            pos_q <= pos_dec;
          end else if (step_r) begin
            pos_q <= pos_inc;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q    <= StIdle;
        hcnt_q  <= '0;
        down_q  <= 1'b0;
        click_q <= 1'b0;
        hold_q  <= 1'b0;
      end else begin
        click_q <= 1'b0;
        hold_q  <= 1'b0;
        unique case (st_q)
          StIdle: begin
            if (filt_c[c]) begin
              st_q   <= StPressed;
              hcnt_q <= '0;
              down_q <= 1'b1;
            end
          end
          StPressed: begin
            if (!filt_c[c]) begin
              st_q    <= StIdle;
              click_q <= 1'b1;
              down_q  <= 1'b0;
            end else if (hcnt_q == HW'(LONG_PRESS - 1)) begin
              st_q   <= StHeld;
              hold_q <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
          StHeld: begin
            if (!filt_c[c]) begin
              st_q   <= StIdle;
              down_q <= 1'b0;
            end
          end
          default: begin
            st_q   <= StIdle;
            down_q <= 1'b0;
          end
        endcase
      end
    end

    assign left[c]                         = left_q;
    assign right[c]                        = right_q;
    assign quadErr[c]                      = err_q;
    assign down[c]                         = down_q;
    assign click[c]                        = click_q;
    assign hold[c]                         = hold_q;
    assign pos[c*POS_WIDTH +: POS_WIDTH]   = pos_q;
  end

endmodule

// File: tb/tb_rotary_encoder_array.sv
// Bench for rotary_encoder_array: a wrapping and a saturating instance share stimulus and are
// checked every cycle against a window/run-length model, plus hand-computed spot checks.
module tb_rotary_encoder_array;

  localparam int CH = 2;
  localparam int QD = 4;
  localparam int BD = 8;
  localparam int LP = 32;
  localparam int PW = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] rotA = '0, rotB = '0, rotCenter = '0, posClr = '0;

  logic [CH-1:0] left_w, right_w, down_w, click_w, hold_w, qerr_w;
  logic [CH*PW-1:0] pos_w;
  logic [CH-1:0] left_s, right_s, down_s, click_s, hold_s, qerr_s;
  logic [CH*PW-1:0] pos_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rotary_encoder_array #(
    .CHANNELS(CH), .QUAD_DEBOUNCE(QD), .BTN_DEBOUNCE(BD), .LONG_PRESS(LP),
    .POS_WIDTH(PW), .WRAP(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .rotA(rotA), .rotB(rotB), .rotCenter(rotCenter), .posClr(posClr),
    .left(left_w), .right(right_w), .down(down_w), .click(click_w), .hold(hold_w),
    .quadErr(qerr_w), .pos(pos_w)
  );

  rotary_encoder_array #(
    .CHANNELS(CH), .QUAD_DEBOUNCE(QD), .BTN_DEBOUNCE(BD), .LONG_PRESS(LP),
    .POS_WIDTH(PW), .WRAP(1'b0)
  ) dut_sat (
    .clk(clk), .rst(rst), .rotA(rotA), .rotB(rotB), .rotCenter(rotCenter), .posClr(posClr),
    .left(left_s), .right(right_s), .down(down_s), .click(click_s), .hold(hold_s),
    .quadErr(qerr_s), .pos(pos_s)
  );

  // ---------------- behavioural model ----------------
  // h*: raw samples, bit 0 = most recent edge. f*1/f*2/f*3: filtered level 1/2/3 edges ago.
  logic [15:0] ha[CH], hb[CH], hc[CH];
  logic [CH-1:0] fa1, fa2, fa3, fb1, fb2, fb3, fc1, fc2;
  logic [CH-1:0] m_left, m_right, m_down, m_click, m_hold, m_err;
  int m_posw[CH], m_poss[CH], run[CH];

  // Filter flips once the N samples taken before the previous edge all disagree with it.
  function automatic logic filt_next(input logic [15:0] h, input logic f, input int n);
    logic [15:0] mask;
    mask = 16'(((1 << n) - 1) << 1);
    if (f) return ((h & mask) == 16'd0) ? 1'b0 : 1'b1;
    return ((h & mask) == mask) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      ha[c] = '0; hb[c] = '0; hc[c] = '0;
      m_posw[c] = 0; m_poss[c] = 0; run[c] = 0;
    end
    fa1 = '0; fa2 = '0; fa3 = '0; fb1 = '0; fb2 = '0; fb3 = '0; fc1 = '0; fc2 = '0;
    m_left = '0; m_right = '0; m_down = '0; m_click = '0; m_hold = '0; m_err = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      logic [1:0] p_old, p_new;
      int nr;
      nr = fc1[c] ? run[c] + 1 : 0;
      m_down[c]  = fc1[c];
      m_hold[c]  = fc1[c] && (nr == LP + 1);
      m_click[c] = !fc1[c] && fc2[c] && (run[c] <= LP);
      run[c] = nr;

      p_old = {fa3[c], fb3[c]};
      p_new = {fa2[c], fb2[c]};
      m_left[c]  = (p_old == 2'b10) && (p_new == 2'b11);
      m_right[c] = (p_old == 2'b01) && (p_new == 2'b11);
      if (posClr[c]) begin
        m_posw[c] = 0; m_poss[c] = 0; m_err[c] = 1'b0;
      end else begin
        if ((p_old ^ p_new) == 2'b11) m_err[c] = 1'b1;
        if (m_left[c]) begin
          m_posw[c] = (m_posw[c] + PMAX) % (PMAX + 1);
          if (m_poss[c] > 0) m_poss[c] = m_poss[c] - 1;
        end
        if (m_right[c]) begin
          m_posw[c] = (m_posw[c] + 1) % (PMAX + 1);
          if (m_poss[c] < PMAX) m_poss[c] = m_poss[c] + 1;
        end
      end

      fa3[c] = fa2[c]; fa2[c] = fa1[c]; fa1[c] = filt_next(ha[c], fa1[c], QD);
      fb3[c] = fb2[c]; fb2[c] = fb1[c]; fb1[c] = filt_next(hb[c], fb1[c], QD);
      fc2[c] = fc1[c]; fc1[c] = filt_next(hc[c], fc1[c], BD);
      ha[c] = {ha[c][14:0], rotA[c]};
      hb[c] = {hb[c][14:0], rotB[c]};
      hc[c] = {hc[c][14:0], rotCenter[c]};
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  int n_left[CH], n_right[CH], n_down[CH], n_click[CH], n_hold[CH];
  int n_rs = 0, n_ls = 0, ncyc = 0, t_down = 0, t_hold = 0;
  logic down_prev = 1'b0;

  initial begin
    for (int c = 0; c < CH; c++) begin
      n_left[c] = 0; n_right[c] = 0; n_down[c] = 0; n_click[c] = 0; n_hold[c] = 0;
    end
    forever begin
      logic [CH*PW-1:0] ew, es;
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        ew[c*PW +: PW] = PW'(m_posw[c]);
        es[c*PW +: PW] = PW'(m_poss[c]);
      end
      chk("left", left_w, m_left);     chk("right", right_w, m_right);
      chk("down", down_w, m_down);     chk("click", click_w, m_click);
      chk("hold", hold_w, m_hold);     chk("quadErr", qerr_w, m_err);
      chk("pos", pos_w, ew);
      chk("left_sat", left_s, m_left); chk("right_sat", right_s, m_right);
      chk("down_sat", down_s, m_down); chk("click_sat", click_s, m_click);
      chk("hold_sat", hold_s, m_hold); chk("quadErr_sat", qerr_s, m_err);
      chk("pos_sat", pos_s, es);
      ncyc++;
      for (int c = 0; c < CH; c++) begin
        n_left[c] += int'(left_w[c]);  n_right[c] += int'(right_w[c]);
        n_down[c] += int'(down_w[c]);  n_click[c] += int'(click_w[c]);
        n_hold[c] += int'(hold_w[c]);
      end
      n_rs += int'(right_s[0]);
      n_ls += int'(left_s[0]);
      if (down_w[0] && !down_prev) t_down = ncyc;
      if (hold_w[0]) t_hold = ncyc;
      down_prev = down_w[0];
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input int c, input logic a, input logic b);
    rotA[c] = a;
    rotB[c] = b;
    cyc(10);
  endtask

  task automatic detent_right(input int c);
    set_ab(c, 1'b0, 1'b1);
    set_ab(c, 1'b1, 1'b1);
    set_ab(c, 1'b1, 1'b0);
    set_ab(c, 1'b0, 1'b0);
  endtask

  initial begin
    int b_l, b_r, b_c, b_h, b_d, b_rs;
    #1 rst = 1'b0;
    cyc(3);
    #2 rst = 1'b1;
    cyc(3);

    // 1: left detent with exact latency, wrap to 15 / floor at 0; then a right detent
    rotA[0] = 1'b1;
    cyc(20);
    rotB[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 7) chk("left0_early", left_w[0], 1'b0);
      if (k == 8) begin
        chk("left0_at_latency", left_w[0], 1'b1);
        chk("pos0_wrap_under", pos_w[PW-1:0], 4'd15);
        chk("left0_sat_pulse", left_s[0], 1'b1);
        chk("pos0_sat_floor", pos_s[PW-1:0], 4'd0);
      end
      if (k == 9) chk("left0_one_cycle", left_w[0], 1'b0);
    end
    cyc(5);
    set_ab(0, 1'b1, 1'b0);
    set_ab(0, 1'b0, 1'b0);
    set_ab(0, 1'b0, 1'b1);
    set_ab(0, 1'b1, 1'b1);
    chk("pos0_after_right", pos_w[PW-1:0], 4'd0);
    chk("pos0_sat_after_right", pos_s[PW-1:0], 4'd1);
    set_ab(0, 1'b0, 1'b1);
    set_ab(0, 1'b0, 1'b0);

    // 2: short glitches on channel 1
    b_l = n_left[1]; b_r = n_right[1];
    rotA[1] = 1'b1; cyc(3); rotA[1] = 1'b0; cyc(10);
    rotB[1] = 1'b1; cyc(3); rotB[1] = 1'b0; cyc(10);
    chk("glitch_pos1", pos_w[2*PW-1:PW], 4'd0);
    chk("glitch_no_steps", n_left[1] + n_right[1], b_l + b_r);

    // 3: saturation at the top, wrap through 15
    posClr[0] = 1'b1; cyc(1); posClr[0] = 1'b0;
    repeat (14) detent_right(0);
    chk("pos0_sat_14", pos_s[PW-1:0], 4'd14);
    for (int k = 0; k < 3; k++) begin
      b_rs = n_rs;
      detent_right(0);
      chk("pos0_sat_top", pos_s[PW-1:0], 4'd15);
      chk("right_sat_pulse", n_rs - b_rs, 1);
    end
    chk("pos0_wrap_over", pos_w[PW-1:0], 4'd1);

    // 4: short press -> click; long press -> hold 32 cycles after down
    b_d = n_down[0]; b_c = n_click[0]; b_h = n_hold[0];
    rotCenter[0] = 1'b1; cyc(20); rotCenter[0] = 1'b0; cyc(15);
    chk("short_down_len", n_down[0] - b_d, 20);
    chk("short_click", n_click[0] - b_c, 1);
    chk("short_no_hold", n_hold[0] - b_h, 0);
    b_c = n_click[0]; b_h = n_hold[0];
    rotCenter[0] = 1'b1; cyc(60); rotCenter[0] = 1'b0; cyc(15);
    chk("hold_delay", t_hold - t_down, LP);
    chk("long_hold", n_hold[0] - b_h, 1);
    chk("long_no_click", n_click[0] - b_c, 0);

    // 5: both phases at once, then clear colliding with a step
    b_l = n_left[0]; b_r = n_right[0];
    rotA[0] = 1'b1; rotB[0] = 1'b1; cyc(12);
    chk("double_err", qerr_w[0], 1'b1);
    chk("double_no_step", (n_left[0] - b_l) + (n_right[0] - b_r), 0);
    set_ab(0, 1'b0, 1'b1);
    set_ab(0, 1'b0, 1'b0);
    set_ab(0, 1'b0, 1'b1);
    rotA[0] = 1'b1;
    cyc(7);
    posClr[0] = 1'b1; cyc(1); posClr[0] = 1'b0; cyc(2);
    chk("clr_wins_pos", pos_w[PW-1:0], 4'd0);
    chk("clr_wins_pos_sat", pos_s[PW-1:0], 4'd0);
    chk("clr_err", qerr_w[0], 1'b0);

    // 6: reset mid-press and mid-rotation, inputs held high through release
    rotCenter[0] = 1'b1; rotA[1] = 1'b1;
    cyc(15);
    #2 rst = 1'b0;
    #1;
    chk("rst_flags", {left_w, right_w, down_w, click_w, hold_w, qerr_w}, 32'd0);
    chk("rst_pos", {pos_w, pos_s}, 32'd0);
    chk("rst_sat_flags", {left_s, right_s, down_s, click_s, hold_s, qerr_s}, 32'd0);
    cyc(2);
    b_c = n_click[0]; b_h = n_hold[0];
    #2 rst = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k == 9)  chk("rel_down_early", down_w[0], 1'b0);
      if (k == 10) chk("rel_down_rise", down_w[0], 1'b1);
    end
    chk("rel_no_click_hold", (n_click[0] - b_c) + (n_hold[0] - b_h), 0);
    chk("rel_double_err", qerr_w[0], 1'b1);
    rotCenter[0] = 1'b0;
    cyc(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
